// File: rtl/reg_bank_reader.sv
// reg_bank_reader
// Architectural register bank for the multicycle MIPS datapath.
// - 32 x DATA_W general registers. Register 0 is hardwired to zero because
//   writes to it are dropped. Register SP_INDEX resets to SP_RESET.
// - Two combinational read ports (read_reg1/2 -> read_data1/2), with no
//   write-to-read forwarding.
// - A/B operand latches (a_out/b_out) load from the read ports on load_ab.
//   With BYPASS=1 a write on the same edge is forwarded into the latch.
// - Dump port: dump_start streams out registers 0..31 on dump_index/dump_data.
//   Each word's data is snapshotted on the edge that its index is loaded.
//   dump_done pulses for one cycle after index 31 is accepted.
//
// Handshake: a dump word transfers on a rising edge where dump_valid and
// dump_ready are both 1. While dump_valid=1 and dump_ready=0, dump_index and
// dump_data hold stable. dump_valid never drops until its word is accepted.
// The only exception is reset.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   reg_write/write_reg/write_data  write port
//   read_reg1/2 -> read_data1/2  combinational read ports
//   load_ab -> a_out/b_out        registered operand latches
//   dump_start, dump_ready        dump request / consumer acceptance
//   dump_valid, dump_index, dump_data, dump_done   dump stream outputs
module reg_bank_reader #(
  parameter int DATA_W   = 32,
  parameter int SP_INDEX = 29,
  parameter int SP_RESET = 227,
  parameter bit BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              load_ab,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] SP_RESET_V = DATA_W'(SP_RESET);

  logic [DATA_W-1:0] regs [32];

  // Dump FSM state. It is kept as a named signal so debug logic and
  // checkers can observe it.
  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              wr_en;
  logic [DATA_W-1:0] a_next, b_next;

  assign wr_en = reg_write && (write_reg != 5'd0);

  // Register array and write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET_V : '0;
      end
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  assign read_data1 = regs[read_reg1];
  assign read_data2 = regs[read_reg2];

  // With BYPASS, a matching same-edge write wins over the array contents.
  // wr_en already excludes index 0, so reg 0 still loads as zero.
  always_comb begin
    a_next = read_data1;
    b_next = read_data2;
    if (BYPASS && wr_en && (write_reg == read_reg1)) a_next = write_data;
    if (BYPASS && wr_en && (write_reg == read_reg2)) b_next = write_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_out <= '0;
      b_out <= '0;
    end else if (load_ab) begin
      a_out <= a_next;
      b_out <= b_next;
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Dump FSM next-state logic. Array reads here see pre-edge contents, so a
  // write on the load edge is not reflected in the snapshot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SCAN;
          idx_d   = 5'd0;
          data_d  = regs[0];
        end
      end
      SCAN: begin
        if (dump_ready) begin
          if (idx_q == 5'd31) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 5'd1;
            data_d = regs[idx_q + 5'd1];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dump_valid = (state_q == SCAN);
  assign dump_done  = (state_q == DONE);
  assign dump_index = idx_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
module tb_reg_bank_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic        load_ab;
  logic        dump_start, dump_ready;

  logic [31:0] rd1_0, rd2_0, a_0, b_0, dd_0;
  logic        dv_0, dn_0;
  logic [4:0]  di_0;
  logic [31:0] rd1_1, rd2_1, a_1, b_1, dd_1;
  logic        dv_1, dn_1;
  logic [4:0]  di_1;

  reg_bank_reader #(.DATA_W(32), .SP_INDEX(29), .SP_RESET(227), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_0), .read_data2(rd2_0), .load_ab(load_ab), .a_out(a_0),
    .b_out(b_0), .dump_start(dump_start), .dump_valid(dv_0), .dump_ready(dump_ready),
    .dump_index(di_0), .dump_data(dd_0), .dump_done(dn_0)
  );

  reg_bank_reader #(.DATA_W(32), .SP_INDEX(29), .SP_RESET(227), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_1), .read_data2(rd2_1), .load_ab(load_ab), .a_out(a_1),
    .b_out(b_1), .dump_start(dump_start), .dump_valid(dv_1), .dump_ready(dump_ready),
    .dump_index(di_1), .dump_data(dd_1), .dump_done(dn_1)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int errors  = 0;
  logic [31:0] model [32];
  logic [36:0] exp_q [$];   // {index, data} of each expected dump beat

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cycle(input logic [4:0] idx, input logic [31:0] val);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = val;
    tick();
    reg_write  = 1'b0;
    if (idx != 5'd0) model[idx] = val;
  endtask

  // Full dump. The expected beats are pushed at start, because no write lands
  // on an index before it is loaded. In stall mode, dump_ready is random. A
  // write to reg 5 happens while reg 5 is presented, and stray dump_start
  // pulses are injected.
  task automatic run_dump(input bit stall_mode);
    int          beats = 0;
    int          cycles = 0;
    bit          wrote = 1'b0;
    bit          rdy;
    logic [36:0] e;
    for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), model[k]});
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    while (beats < 32 && cycles < 2000) begin
      cycles++;
      if (!dv_0) begin
        check("dump_valid_held", {63'd0, dv_0}, 64'd1);
        break;
      end
      rdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_mode && di_0 == 5'd5 && !wrote) begin
        rdy        = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'h0000FFFF;
        model[5]   = 32'h0000FFFF;
        wrote      = 1'b1;
      end
      if (stall_mode && $urandom_range(0, 3) == 0) dump_start = 1'b1;
      if (rdy) begin
        e = exp_q.pop_front();
        check("dump_index", {59'd0, di_0}, {59'd0, e[36:32]});
        check("dump_data", {32'd0, dd_0}, {32'd0, e[31:0]});
        beats++;
      end
      dump_ready = rdy;
      tick();
      reg_write  = 1'b0;
      dump_start = 1'b0;
    end
    dump_ready = 1'b0;
    check("dump_beats", 64'(beats), 64'd32);
    check("dump_valid_after_last", {63'd0, dv_0}, 64'd0);
    check("dump_done_pulse", {63'd0, dn_0}, 64'd1);
    tick();
    check("dump_done_single", {63'd0, dn_0}, 64'd0);
    check("dump_idle_valid", {63'd0, dv_0}, 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0; load_ab = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state.
    check("rst_a", {32'd0, a_0}, 64'd0);
    check("rst_b", {32'd0, b_0}, 64'd0);
    check("rst_valid", {63'd0, dv_0}, 64'd0);
    check("rst_done", {63'd0, dn_0}, 64'd0);
    check("rst_dump_index", {59'd0, di_0}, 64'd0);
    check("rst_dump_data", {32'd0, dd_0}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      check("rst_read1", {32'd0, rd1_0}, (i == 29) ? 64'd227 : 64'd0);
      check("rst_read2", {32'd0, rd2_0}, (31 - i == 29) ? 64'd227 : 64'd0);
    end

    // Write to reg 0 is dropped. The write to reg 31 shows only after the edge.
    write_cycle(5'd0, 32'hDEADBEEF);
    read_reg1 = 5'd0;
    read_reg2 = 5'd31;
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h12345678;
    #1;
    check("no_forward_rd2", {32'd0, rd2_0}, 64'd0);
    tick();
    reg_write = 1'b0;
    model[31] = 32'h12345678;
    check("reg0_zero", {32'd0, rd1_0}, 64'd0);
    check("reg31_written", {32'd0, rd2_0}, 64'h12345678);

    // Same-edge write plus load_ab on reg 8.
    write_cycle(5'd8, 32'h00000011);
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hA5A5A5A5;
    load_ab = 1'b1; read_reg1 = 5'd8; read_reg2 = 5'd29;
    #1;
    check("pre_edge_rd1", {32'd0, rd1_0}, 64'h11);
    tick();
    reg_write = 1'b0; load_ab = 1'b0;
    model[8] = 32'hA5A5A5A5;
    check("nobypass_a", {32'd0, a_0}, 64'h11);
    check("bypass_a", {32'd0, a_1}, 64'hA5A5A5A5);
    check("nobypass_b", {32'd0, b_0}, 64'd227);
    check("bypass_b", {32'd0, b_1}, 64'd227);
    check("rd1_after", {32'd0, rd1_0}, 64'hA5A5A5A5);

    // A/B hold without load_ab.
    read_reg1 = 5'd31; read_reg2 = 5'd0;
    tick();
    check("a_hold", {32'd0, a_0}, 64'h11);
    check("b_hold", {32'd0, b_1}, 64'd227);

    // A write to reg 0 is never bypassed into A.
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hCAFEF00D;
    load_ab = 1'b1; read_reg1 = 5'd0; read_reg2 = 5'd31;
    tick();
    reg_write = 1'b0; load_ab = 1'b0;
    check("bypass_reg0_a", {32'd0, a_1}, 64'd0);
    check("load_b31", {32'd0, b_0}, 64'h12345678);

    // Preload reg k = k*4, then run a full-speed dump and a stalled dump.
    for (int k = 1; k < 32; k++) write_cycle(5'(k), 32'(k * 4));
    read_reg1 = 5'd29;
    #1;
    check("preload_29", {32'd0, rd1_0}, 64'd116);
    run_dump(1'b0);
    run_dump(1'b1);
    read_reg1 = 5'd5;
    #1;
    check("reg5_after_stall_write", {32'd0, rd1_0}, 64'h0000FFFF);

    // Reset while in SCAN at index 12.
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int c = 0; c < 100 && di_0 != 5'd12; c++) tick();
    dump_ready = 1'b0;
    check("mid_dump_index", {59'd0, di_0}, 64'd12);
    check("mid_dump_valid", {63'd0, dv_0}, 64'd1);
    reset_n = 1'b0;
    tick();
    model_reset();
    check("rst_mid_valid", {63'd0, dv_0}, 64'd0);
    check("rst_mid_done", {63'd0, dn_0}, 64'd0);
    check("rst_mid_state", {62'd0, dut0.state_q}, 64'd0);
    check("rst_mid_index", {59'd0, di_0}, 64'd0);
    reset_n = 1'b1;
    read_reg1 = 5'd29; read_reg2 = 5'd12;
    tick();
    check("post_rst_done", {63'd0, dn_0}, 64'd0);
    check("post_rst_valid", {63'd0, dv_0}, 64'd0);
    check("post_rst_sp", {32'd0, rd1_0}, {32'd0, model[29]});
    check("post_rst_r12", {32'd0, rd2_0}, {32'd0, model[12]});
    check("post_rst_a", {32'd0, a_0}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
